cacheline_adaptor: RTL and testbench

- Memory-side responder for the L1 I-cache line interface.
- Accepts 256-bit line read and line write requests from the cache.
- Converts each request into a 4-beat, 64-bit burst on the physical memory/L2 bus.
- Returns the assembled line together with a single-cycle done pulse.

---
 rtl/cacheline_adaptor.sv | 128 ++++++++++++
 tb/tb_cacheline_adaptor.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// Cache-line to memory-burst adaptor: turns one line read/write request from the
// I-cache into a BURST_LEN-beat burst and returns the line with a one-cycle resp.
module cacheline_adaptor #(
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 mmem_addr,
  input  logic                        mmem_read,
  input  logic                        mmem_write,
  input  logic [DATA_W*BURST_LEN-1:0] mmem_wdata,
  output logic [DATA_W*BURST_LEN-1:0] mmem_rdata,
  output logic                        mmem_resp,
  output logic [31:0]                 burst_addr,
  output logic                        burst_read,
  output logic                        burst_write,
  output logic [DATA_W-1:0]           burst_wdata,
  input  logic [DATA_W-1:0]           burst_rdata,
  input  logic                        burst_resp
);

  localparam int LINE_W   = DATA_W * BURST_LEN;
  localparam int CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_LEN - 1);
  localparam logic [31:0]      ALIGN_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [LINE_W-1:0] wline;
  logic [LINE_W-1:0] rbuf;
  logic [LINE_W-1:0] rbuf_merged;
  logic              last_beat;

  assign last_beat = (count == LAST_BEAT);

  // Read line being assembled, with the current beat dropped into its slot, so the
  // final beat can be published to mmem_rdata on the same edge it arrives.
  generate
    for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_beat
      assign rbuf_merged[gi*DATA_W +: DATA_W] =
        (count == CNT_W'(gi)) ? burst_rdata : rbuf[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    burst_wdata = '0;
    for (int i = 0; i < BURST_LEN; i++) begin
      if (count == CNT_W'(i)) begin
        burst_wdata = wline[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      wline       <= '0;
      rbuf        <= '0;
      mmem_rdata  <= '0;
      mmem_resp   <= 1'b0;
      burst_addr  <= '0;
      burst_read  <= 1'b0;
      burst_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mmem_resp <= 1'b0;
          // Writeback takes priority so a dirty victim leaves before the fill.
          if (mmem_write) begin
            burst_addr  <= mmem_addr & ALIGN_MASK;
            wline       <= mmem_wdata;
            count       <= '0;
            burst_write <= 1'b1;
            state       <= WRITE;
          end else if (mmem_read) begin
            burst_addr <= mmem_addr & ALIGN_MASK;
            count      <= '0;
            burst_read <= 1'b1;
            state      <= READ;
          end
        end
        READ: begin
          if (burst_resp) begin
            rbuf <= rbuf_merged;
            if (last_beat) begin
              mmem_rdata <= rbuf_merged;
              burst_read <= 1'b0;
              mmem_resp  <= 1'b1;
              state      <= DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        WRITE: begin
          if (burst_resp) begin
            if (last_beat) begin
              burst_write <= 1'b0;
              mmem_resp   <= 1'b1;
              state       <= DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          mmem_resp <= 1'b0;
          count     <= '0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: the bench plays both cache and memory, with a
// line-level reference model (expected line, beat order, latency = 6 + waits).
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mmem_addr;
  logic         mmem_read;
  logic         mmem_write;
  logic [255:0] mmem_wdata;
  logic [255:0] mmem_rdata;
  logic         mmem_resp;
  logic [31:0]  burst_addr;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int tests  = 0;
  int failed = 0;
  logic [255:0] last_line;

  cacheline_adaptor #(.DATA_W(64), .BURST_LEN(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mmem_addr   (mmem_addr),
    .mmem_read   (mmem_read),
    .mmem_write  (mmem_write),
    .mmem_wdata  (mmem_wdata),
    .mmem_rdata  (mmem_rdata),
    .mmem_resp   (mmem_resp),
    .burst_addr  (burst_addr),
    .burst_read  (burst_read),
    .burst_write (burst_write),
    .burst_wdata (burst_wdata),
    .burst_rdata (burst_rdata),
    .burst_resp  (burst_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Memory-side bus model plus transaction-level expectations. Requests are already
  // driven by the caller; returns on the negedge where mmem_resp is seen.
  // extra = idle cycles before the request can be accepted.
  task automatic serve(input bit exp_write, input string name, input logic [255:0] wline,
                       input logic [255:0] beats, input logic [15:0] pat, input int pat_len,
                       input int wait_pct, input bit stray, input int extra);
    int n = 0, waits = 0, pi = 0, at = 0;
    bit got = 0, busy, other, r;
    logic [255:0] rl = '0;
    logic [31:0]  al;
    al = {mmem_addr[31:5], 5'b0};
    for (int idx = 1; idx <= 300 && !got; idx++) begin
      @(negedge clk);
      if (mmem_resp === 1'b1) begin
        got = 1; at = idx; burst_resp = 1'b0;
      end else begin
        busy  = exp_write ? burst_write : burst_read;
        other = exp_write ? burst_read  : burst_write;
        if (other !== 1'b0) begin
          tests++; failed++;
          $display("FAIL %s wrong_burst_dir: read=%b write=%b", name, burst_read, burst_write);
        end
        if (busy === 1'b1) begin
          tests++;
          if (burst_addr !== al) begin
            failed++;
            $display("FAIL %s burst_addr: got %h want %h", name, burst_addr, al);
          end
          tests++;
          if (mmem_rdata !== last_line) begin
            failed++;
            $display("FAIL %s rdata_stable: got %h want %h", name, mmem_rdata, last_line);
          end
          if (n >= 4) begin
            tests++; failed++;
            $display("FAIL %s extra_beat: beats=%0d still busy", name, n);
            burst_resp = 1'b0;
          end else begin
            if (exp_write) begin
              tests++;
              if (burst_wdata !== wline[64*n +: 64]) begin
                failed++;
                $display("FAIL %s wdata_beat%0d: got %h want %h", name, n, burst_wdata, wline[64*n +: 64]);
              end
            end
            if (pat_len > 0) begin
              r = (pi < pat_len) ? pat[pi] : 1'b1;
              pi++;
            end else begin
              r = ($urandom_range(99) >= wait_pct);
            end
            if (r) begin
              burst_resp  = 1'b1;
              burst_rdata = beats[64*n +: 64];
              rl[64*n +: 64] = beats[64*n +: 64];
              n++;
            end else begin
              burst_resp  = 1'b0;
              burst_rdata = {$urandom, $urandom};
              waits++;
            end
          end
        end else begin
          burst_resp  = stray ? 1'($urandom_range(1)) : 1'b0;
          burst_rdata = {$urandom, $urandom};
        end
      end
    end
    if (!got) begin
      tests++; failed++;
      $display("FAIL %s timeout: no mmem_resp after 300 cycles, beats=%0d", name, n);
    end else begin
      tests++;
      if (n != 4 || at != 5 + waits + extra) begin
        failed++;
        $display("FAIL %s latency: beats=%0d resp_cycle=%0d want beats=4 resp_cycle=%0d",
                 name, n, at + 1, 6 + waits + extra);
      end
      tests++;
      if (burst_read !== 1'b0 || burst_write !== 1'b0) begin
        failed++;
        $display("FAIL %s done_bursts: read=%b write=%b want 0", name, burst_read, burst_write);
      end
      if (!exp_write) last_line = rl;
      tests++;
      if (mmem_rdata !== last_line) begin
        failed++;
        $display("FAIL %s done_rdata: got %h want %h", name, mmem_rdata, last_line);
      end
    end
    $display("[TB] %s %s addr=%h waits=%0d resp_cycle=%0d", name, exp_write ? "write" : "read",
             al, waits, at + 1);
  endtask

  task automatic test_reset();
    rst = 1'b1; mmem_read = 0; mmem_write = 0; mmem_addr = '0; mmem_wdata = '0;
    burst_rdata = '0; burst_resp = 0;
    #1;
    tests++;
    if ({mmem_rdata, mmem_resp, burst_addr, burst_read, burst_write, burst_wdata} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: rdata=%h resp=%b addr=%h rd=%b wr=%b wdata=%h",
               mmem_rdata, mmem_resp, burst_addr, burst_read, burst_write, burst_wdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_line = '0;
    @(negedge clk);
    tests++;
    if (burst_read !== 1'b0 || burst_write !== 1'b0 || mmem_resp !== 1'b0) begin
      failed++;
      $display("FAIL reset_idle: rd=%b wr=%b resp=%b", burst_read, burst_write, mmem_resp);
    end
    $display("[TB] reset checked");
  endtask

  task automatic drop_and_check_idle(input string name);
    mmem_read = 0; mmem_write = 0;
    @(negedge clk);
    tests++;
    if (mmem_resp !== 1'b0 || burst_read !== 1'b0 || burst_write !== 1'b0) begin
      failed++;
      $display("FAIL %s after_done: resp=%b rd=%b wr=%b want 0", name, mmem_resp, burst_read, burst_write);
    end
  endtask

  task automatic test_read_zero_wait();
    logic [255:0] b;
    b = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    mmem_addr = 32'h0000_1234; mmem_read = 1;
    serve(0, "read_zero_wait", '0, b, 16'h0, 0, 0, 0, 0);
    tests++;
    if (mmem_rdata !== b) begin
      failed++;
      $display("FAIL read_zero_wait line: got %h want %h", mmem_rdata, b);
    end
    drop_and_check_idle("read_zero_wait");
  endtask

  task automatic test_write_waits();
    logic [255:0] w;
    w = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
    mmem_addr = 32'h8000_0040; mmem_wdata = w; mmem_write = 1;
    // resp pattern 1,0,0,1,1,0,1 in order, bit 0 first
    serve(1, "write_waits", w, '0, 16'b1011001, 7, 0, 0, 0);
    drop_and_check_idle("write_waits");
  endtask

  task automatic test_read_write_both();
    logic [255:0] w, b;
    w = rand_line(); b = rand_line();
    mmem_addr = $urandom; mmem_wdata = w; mmem_write = 1; mmem_read = 1;
    serve(1, "both_write", w, '0, 16'h0, 0, 25, 0, 0);
    mmem_write = 0;
    mmem_wdata = rand_line();
    serve(0, "both_read", '0, b, 16'h0, 0, 25, 0, 1);
    drop_and_check_idle("both_read");
  endtask

  task automatic test_reset_mid_read();
    mmem_addr = $urandom; mmem_read = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      burst_resp = 1; burst_rdata = {$urandom, $urandom};
      @(negedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (burst_read !== 1'b0 || burst_write !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_read bursts: rd=%b wr=%b want 0", burst_read, burst_write);
    end
    tests++;
    if ({mmem_rdata, mmem_resp, burst_addr, burst_wdata} !== '0) begin
      failed++;
      $display("FAIL reset_mid_read outputs: rdata=%h resp=%b addr=%h wdata=%h",
               mmem_rdata, mmem_resp, burst_addr, burst_wdata);
    end
    mmem_read = 0; burst_resp = 0;
    @(negedge clk);
    rst = 1'b0;
    last_line = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (mmem_resp !== 1'b0 || burst_read !== 1'b0) begin
        failed++;
        $display("FAIL reset_mid_read ghost: resp=%b rd=%b want 0", mmem_resp, burst_read);
      end
    end
    mmem_addr = $urandom; mmem_read = 1;
    serve(0, "read_after_reset", '0, rand_line(), 16'h0, 0, 20, 0, 0);
    drop_and_check_idle("read_after_reset");
  endtask

  task automatic test_stray_resp();
    for (int k = 0; k < 4; k++) begin
      burst_resp = 1; burst_rdata = {$urandom, $urandom};
      @(negedge clk);
    end
    burst_resp = 1;
    mmem_addr = $urandom; mmem_read = 1;
    serve(0, "stray_resp", '0, rand_line(), 16'h0, 0, 0, 1, 0);
    drop_and_check_idle("stray_resp");
  endtask

  task automatic test_back_to_back();
    mmem_addr = $urandom; mmem_read = 1;
    serve(0, "b2b_first", '0, rand_line(), 16'h0, 0, 30, 1, 0);
    mmem_read = 0;
    @(negedge clk);
    mmem_addr = $urandom; mmem_read = 1;
    serve(0, "b2b_second", '0, rand_line(), 16'h0, 0, 30, 1, 0);
    drop_and_check_idle("b2b_second");
  endtask

  task automatic test_random();
    bit wr;
    logic [255:0] w;
    for (int t = 0; t < 12; t++) begin
      wr = 1'($urandom_range(1));
      w  = rand_line();
      mmem_addr = $urandom; mmem_wdata = w;
      if (wr) mmem_write = 1; else mmem_read = 1;
      serve(wr, "random", w, rand_line(), 16'h0, 0, 35, 1, 0);
      mmem_wdata = rand_line();
      mmem_addr  = $urandom;
      drop_and_check_idle("random");
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_read_write_both();
    test_reset_mid_read();
    test_stray_resp();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
